// File: rtl/aq_axis_djpeg_pack.sv
// Pixel packer for the JPEG decoder output: PPB pixels per AXI4-Stream beat,
// beats never span lines, buffered in a first-word-fall-through FIFO.
module aq_axis_djpeg_pack #(
    parameter int PPB        = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          TCLK,
    input  logic                          RST,
    input  logic                          LAST_MODE,
    input  logic                          CLR_ERR,
    input  logic                          S_PIX_VALID,
    output logic                          S_PIX_READY,
    input  logic [7:0]                    S_PIX_R,
    input  logic [7:0]                    S_PIX_G,
    input  logic [7:0]                    S_PIX_B,
    input  logic [15:0]                   S_PIX_X,
    input  logic [15:0]                   S_PIX_Y,
    input  logic [15:0]                   S_WIDTH,
    input  logic [15:0]                   S_HEIGHT,
    output logic [32*PPB-1:0]             M_AXIS_TDATA,
    output logic [4*PPB-1:0]              M_AXIS_TKEEP,
    output logic [4*PPB-1:0]              M_AXIS_TSTRB,
    output logic                          M_AXIS_TUSER,
    output logic                          M_AXIS_TLAST,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          FRAME_DONE,
    output logic                          SEQ_ERR
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = (PPB > 1) ? $clog2(PPB) : 1;
    localparam int DW = 32 * PPB;
    localparam int KW = 4 * PPB;
    localparam int EW = DW + KW + 3;

    logic          rst_d;
    logic          full, empty, accept, take, bad_size, eol, eof, flush, pop, err_set;
    logic [LW-1:0] lane;
    logic [DW-1:0] acc_data, nxt_data;
    logic [KW-1:0] acc_keep, nxt_keep;
    logic          acc_sof, nxt_sof;
    logic [15:0]   exp_x;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          frame_done, seq_err;

    always_ff @(posedge TCLK) rst_d <= RST;

    assign full     = (level == (AW+1)'(FIFO_DEPTH));
    assign empty    = (level == '0);
    // Ready is held low for one extra cycle after reset so the bench/upstream sees a clean idle cycle.
    assign S_PIX_READY = !RST && !rst_d && !full;
    assign accept   = S_PIX_VALID && S_PIX_READY;
    assign bad_size = (S_WIDTH == 16'd0) || (S_HEIGHT == 16'd0);
    assign take     = accept && !bad_size;
    assign eol      = (S_PIX_X == S_WIDTH - 16'd1);
    assign eof      = eol && (S_PIX_Y == S_HEIGHT - 16'd1);
    assign flush    = take && ((lane == LW'(PPB - 1)) || eol);
    assign err_set  = accept && (bad_size || (S_PIX_X != exp_x));

    always_comb begin
        nxt_data = acc_data;
        nxt_keep = acc_keep;
        nxt_sof  = acc_sof || ((S_PIX_X == 16'd0) && (S_PIX_Y == 16'd0));
        for (int k = 0; k < PPB; k++) begin
            if (lane == LW'(k)) begin
                nxt_data[32*k +: 32] = {8'd0, S_PIX_R, S_PIX_G, S_PIX_B};
                nxt_keep[4*k +: 4]   = 4'hF;
            end
        end
    end

    always_ff @(posedge TCLK) begin
        if (RST) begin
            lane     <= '0;
            acc_data <= '0;
            acc_keep <= '0;
            acc_sof  <= 1'b0;
            exp_x    <= 16'd0;
        end else if (take) begin
            exp_x <= eol ? 16'd0 : S_PIX_X + 16'd1;
            if (flush) begin
                lane     <= '0;
                acc_data <= '0;
                acc_keep <= '0;
                acc_sof  <= 1'b0;
            end else begin
                lane     <= lane + LW'(1);
                acc_data <= nxt_data;
                acc_keep <= nxt_keep;
                acc_sof  <= nxt_sof;
            end
        end
    end

    // Entry layout, LSB first: eof, eol, sof, keep, data.
    always_ff @(posedge TCLK) begin
        if (flush) mem[wr_ptr] <= {nxt_data, nxt_keep, nxt_sof, eol, eof};
    end

    assign head = mem[rd_ptr];
    assign pop  = !empty && M_AXIS_TREADY;

    always_ff @(posedge TCLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            if (flush) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({flush, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            frame_done <= pop && head[0];
            if (err_set)      seq_err <= 1'b1;
            else if (CLR_ERR) seq_err <= 1'b0;
        end
    end

    assign M_AXIS_TVALID = !empty;
    assign M_AXIS_TDATA  = empty ? '0 : head[EW-1 -: DW];
    assign M_AXIS_TKEEP  = empty ? '0 : head[KW+2 -: KW];
    assign M_AXIS_TSTRB  = M_AXIS_TKEEP;
    assign M_AXIS_TUSER  = !empty && head[2];
    assign M_AXIS_TLAST  = !empty && (LAST_MODE ? head[1] : head[0]);
    assign FIFO_LEVEL    = level;
    assign FRAME_DONE    = frame_done;
    assign SEQ_ERR       = seq_err;

endmodule

// File: tb/tb_aq_axis_djpeg_pack.sv
// Bench for aq_axis_djpeg_pack: directed vectors on a PPB=2/depth-4 instance,
// randomized frames against a row-chunking model on a PPB=4/depth-16 instance.
module tb_aq_axis_djpeg_pack;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic a_lm, a_clr, a_vld, a_rdy, a_tready, a_tvalid, a_tuser, a_tlast, a_fd, a_err;
    logic [7:0]  a_r, a_g, a_b;
    logic [15:0] a_x, a_y, a_w, a_h;
    logic [63:0] a_tdata;
    logic [7:0]  a_tkeep, a_tstrb;
    logic [2:0]  a_level;

    logic b_lm, b_clr, b_vld, b_rdy, b_tready, b_tvalid, b_tuser, b_tlast, b_fd, b_err;
    logic [7:0]   b_r, b_g, b_b;
    logic [15:0]  b_x, b_y, b_w, b_h;
    logic [127:0] b_tdata;
    logic [15:0]  b_tkeep, b_tstrb;
    logic [4:0]   b_level;

    aq_axis_djpeg_pack #(.PPB(2), .FIFO_DEPTH(4)) u_dut (
        .TCLK(clk), .RST(rst), .LAST_MODE(a_lm), .CLR_ERR(a_clr),
        .S_PIX_VALID(a_vld), .S_PIX_READY(a_rdy),
        .S_PIX_R(a_r), .S_PIX_G(a_g), .S_PIX_B(a_b), .S_PIX_X(a_x), .S_PIX_Y(a_y),
        .S_WIDTH(a_w), .S_HEIGHT(a_h),
        .M_AXIS_TDATA(a_tdata), .M_AXIS_TKEEP(a_tkeep), .M_AXIS_TSTRB(a_tstrb),
        .M_AXIS_TUSER(a_tuser), .M_AXIS_TLAST(a_tlast), .M_AXIS_TVALID(a_tvalid),
        .M_AXIS_TREADY(a_tready), .FIFO_LEVEL(a_level), .FRAME_DONE(a_fd), .SEQ_ERR(a_err)
    );

    aq_axis_djpeg_pack #(.PPB(4), .FIFO_DEPTH(16)) u_dut4 (
        .TCLK(clk), .RST(rst), .LAST_MODE(b_lm), .CLR_ERR(b_clr),
        .S_PIX_VALID(b_vld), .S_PIX_READY(b_rdy),
        .S_PIX_R(b_r), .S_PIX_G(b_g), .S_PIX_B(b_b), .S_PIX_X(b_x), .S_PIX_Y(b_y),
        .S_WIDTH(b_w), .S_HEIGHT(b_h),
        .M_AXIS_TDATA(b_tdata), .M_AXIS_TKEEP(b_tkeep), .M_AXIS_TSTRB(b_tstrb),
        .M_AXIS_TUSER(b_tuser), .M_AXIS_TLAST(b_tlast), .M_AXIS_TVALID(b_tvalid),
        .M_AXIS_TREADY(b_tready), .FIFO_LEVEL(b_level), .FRAME_DONE(b_fd), .SEQ_ERR(b_err)
    );

    typedef struct {
        int         x;
        int         y;
        logic       flush;
        logic [63:0] data;
        logic [7:0] keep;
        logic       user;
        logic       lastf;
        logic       lastl;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         user;
        logic         last;
    } beat_t;

    int    total = 0;
    int    bad = 0;
    int    fd_a = 0;
    int    fd_b = 0;
    logic  b_rnd = 1'b0;
    beat_t q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out", name);
    endtask

    function automatic logic [31:0] pix(input int x, input int y, input int s);
        logic [7:0] r, g, b;
        r = 8'(x * 7 + s);
        g = 8'(y * 29 + s * 3);
        b = 8'(x + y * 17 + s + 1);
        return {8'd0, r, g, b};
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic a_set(input int x, input int y, input int s);
        logic [31:0] p;
        p   = pix(x, y, s);
        a_r = p[23:16];
        a_g = p[15:8];
        a_b = p[7:0];
        a_x = 16'(x);
        a_y = 16'(y);
    endtask

    // Send one pixel on instance A and let it be accepted at the next edge.
    task automatic a_send(input int x, input int y, input int s);
        a_set(x, y, s);
        a_vld = 1'b1;
        chk("a_ready_before_send", 128'(a_rdy), 128'(1));
        cyc();
        a_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
    endtask

    always @(negedge clk) if (a_fd) fd_a <= fd_a + 1;
    always @(negedge clk) if (b_fd) fd_b <= fd_b + 1;

    task automatic b_mon();
        beat_t e;
        if (b_tvalid && b_tready) begin
            if (q.size() == 0) begin
                chk("b_unexpected_beat", 128'(1), 128'(0));
            end else begin
                e = q.pop_front();
                chk("b_data", b_tdata, e.data);
                chk("b_keep", 128'(b_tkeep), 128'(e.keep));
                chk("b_strb", 128'(b_tstrb), 128'(e.keep));
                chk("b_user_last", 128'({b_tuser, b_tlast}), 128'({e.user, e.last}));
            end
        end
    endtask

    always @(negedge clk) b_mon();

    initial begin
        forever begin
            @(posedge clk);
            #1;
            b_tready = b_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic b_push(input int x, input int y, input int s);
        logic [31:0] p;
        logic        r;
        int          n;
        while ($urandom_range(0, 3) == 0) begin
            b_vld = 1'b0;
            cyc();
        end
        p   = pix(x, y, s);
        b_r = p[23:16];
        b_g = p[15:8];
        b_b = p[7:0];
        b_x = 16'(x);
        b_y = 16'(y);
        b_vld = 1'b1;
        n = 0;
        r = 1'b0;
        while (!r && n < 300) begin
            r = b_rdy;
            cyc();
            n++;
        end
        b_vld = 1'b0;
        if (!r) fail_now("b_pixel_accept");
    endtask

    task automatic b_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || b_tvalid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("b_drain");
    endtask

    // Model: each row is cut into chunks of 4 pixels, the last chunk of a row may be short.
    task automatic b_model(input int w, input int h, input int s, input logic lm);
        beat_t e;
        for (int y = 0; y < h; y++) begin
            for (int x0 = 0; x0 < w; x0 += 4) begin
                e.data = '0;
                e.keep = '0;
                for (int k = 0; k < 4; k++) begin
                    if (x0 + k < w) begin
                        e.data[32*k +: 32] = pix(x0 + k, y, s);
                        e.keep[4*k +: 4]   = 4'hF;
                    end
                end
                e.user = (y == 0) && (x0 == 0);
                e.last = lm ? (x0 + 4 >= w) : ((x0 + 4 >= w) && (y == h - 1));
                q.push_back(e);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[10];
        int   acc, x, fd0, w, h;
        logic r, lm;

        for (int i = 0; i < 10; i++) begin
            tv[i].x     = i % 5;
            tv[i].y     = i / 5;
            tv[i].flush = (tv[i].x % 2 == 1) || (tv[i].x == 4);
            tv[i].data  = '0;
            tv[i].keep  = 8'h00;
            if (tv[i].x == 4) begin
                tv[i].data = {32'd0, pix(4, tv[i].y, 0)};
                tv[i].keep = 8'h0F;
            end else if (tv[i].flush) begin
                tv[i].data = {pix(tv[i].x, tv[i].y, 0), pix(tv[i].x - 1, tv[i].y, 0)};
                tv[i].keep = 8'hFF;
            end
            tv[i].user  = (tv[i].x == 1) && (tv[i].y == 0);
            tv[i].lastl = (tv[i].x == 4);
            tv[i].lastf = (tv[i].x == 4) && (tv[i].y == 1);
        end

        rst = 1'b1;
        {a_lm, a_clr, a_vld, a_tready} = '0;
        {a_r, a_g, a_b} = '0;
        {a_x, a_y, a_w, a_h} = '0;
        {b_lm, b_clr, b_vld} = '0;
        {b_r, b_g, b_b} = '0;
        {b_x, b_y, b_w, b_h} = '0;
        repeat (3) cyc();

        chk("rst_valid_ready_fd_err", 128'({a_tvalid, a_rdy, a_fd, a_err, a_tuser, a_tlast}), 128'(0));
        chk("rst_data_keep_level", 128'({a_tdata, a_tkeep, a_level}), 128'(0));
        rst = 1'b0;
        #2;
        chk("first_cycle_after_rst", 128'({a_tvalid, a_rdy, a_level, a_err}), 128'(0));
        cyc();
        chk("ready_after_rst", 128'(a_rdy), 128'(1));

        // Packing, frame TLAST then line TLAST.
        a_w = 16'd5;
        a_h = 16'd2;
        a_tready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            a_lm = (m == 1);
            fd0 = fd_a;
            for (int i = 0; i < 10; i++) begin
                a_send(tv[i].x, tv[i].y, 0);
                chk("pack_valid", 128'(a_tvalid), 128'(tv[i].flush));
                if (tv[i].flush) begin
                    chk("pack_data", 128'(a_tdata), 128'(tv[i].data));
                    chk("pack_keep", 128'({a_tkeep, a_tstrb}), 128'({tv[i].keep, tv[i].keep}));
                    chk("pack_user", 128'(a_tuser), 128'(tv[i].user));
                    chk("pack_last", 128'(a_tlast), 128'(a_lm ? tv[i].lastl : tv[i].lastf));
                end
            end
            repeat (3) cyc();
            chk("pack_frame_done_count", 128'(fd_a - fd0), 128'(1));
            chk("pack_level_after", 128'(a_level), 128'(0));
        end
        a_lm = 1'b0;

        // Backpressure: 10 pixels offered into a depth-4 FIFO with TREADY low.
        a_tready = 1'b0;
        a_w = 16'd16;
        a_h = 16'd1;
        acc = 0;
        x = 0;
        a_set(0, 0, 0);
        a_vld = 1'b1;
        for (int c = 0; c < 20; c++) begin
            r = a_rdy;
            cyc();
            if (r && x < 10) begin
                acc++;
                x++;
                if (x < 10) a_set(x, 0, 0);
                else a_vld = 1'b0;
            end
        end
        a_vld = 1'b0;
        chk("bp_accepted", 128'(acc), 128'(8));
        chk("bp_level", 128'(a_level), 128'(4));
        chk("bp_ready_low", 128'(a_rdy), 128'(0));
        a_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", 128'(a_tvalid), 128'(1));
            chk("bp_data", 128'(a_tdata), 128'({pix(2*k + 1, 0, 0), pix(2*k, 0, 0)}));
            chk("bp_user", 128'(a_tuser), 128'(k == 0));
            cyc();
            if (k == 0) chk("bp_ready_back", 128'(a_rdy), 128'(1));
        end
        chk("bp_drained", 128'({a_tvalid, a_level}), 128'(0));
        do_reset();

        // Sequence error handling.
        a_w = 16'd8;
        a_h = 16'd1;
        a_send(0, 0, 0);
        chk("seq_err_x0", 128'(a_err), 128'(0));
        a_send(1, 0, 0);
        chk("seq_err_x1", 128'(a_err), 128'(0));
        chk("seq_beat0", 128'(a_tdata), 128'({pix(1, 0, 0), pix(0, 0, 0)}));
        a_send(3, 0, 0);
        chk("seq_err_x3", 128'(a_err), 128'(1));
        a_send(4, 0, 0);
        chk("seq_beat1", 128'({a_tvalid, a_tdata}), 128'({1'b1, pix(4, 0, 0), pix(3, 0, 0)}));
        a_clr = 1'b1;
        cyc();
        a_clr = 1'b0;
        chk("seq_clr", 128'(a_err), 128'(0));
        a_clr = 1'b1;
        a_send(7, 0, 0);
        a_clr = 1'b0;
        chk("seq_set_wins", 128'(a_err), 128'(1));
        a_clr = 1'b1;
        cyc();
        a_clr = 1'b0;
        chk("seq_clr2", 128'(a_err), 128'(0));
        a_w = 16'd0;
        a_send(0, 0, 0);
        chk("seq_zero_width", 128'({a_err, a_tvalid, a_level}), 128'({1'b1, 1'b0, 3'd0}));
        do_reset();

        // Reset in the middle of a frame.
        a_w = 16'd5;
        a_h = 16'd2;
        a_tready = 1'b0;
        a_send(0, 0, 0);
        a_send(1, 0, 0);
        a_send(2, 0, 0);
        chk("mid_level_before", 128'(a_level), 128'(1));
        rst = 1'b1;
        cyc();
        chk("mid_in_reset", 128'({a_tvalid, a_rdy, a_level}), 128'(0));
        rst = 1'b0;
        cyc();
        cyc();
        a_tready = 1'b1;
        a_send(0, 0, 50);
        a_send(1, 0, 50);
        chk("mid_beat0_flags", 128'({a_tvalid, a_tuser, a_tkeep}), 128'({1'b1, 1'b1, 8'hFF}));
        chk("mid_beat0_data", 128'(a_tdata), 128'({pix(1, 0, 50), pix(0, 0, 50)}));
        cyc();

        // Random frames on the PPB=4 instance.
        b_rnd = 1'b1;
        for (int f = 0; f < 200; f++) begin
            b_drain();
            lm = 1'($urandom_range(0, 1));
            w  = int'($urandom_range(1, 17));
            h  = int'($urandom_range(1, 9));
            b_lm = lm;
            b_w  = 16'(w);
            b_h  = 16'(h);
            b_model(w, h, f, lm);
            for (int y = 0; y < h; y++)
                for (int xx = 0; xx < w; xx++)
                    b_push(xx, y, f);
        end
        b_drain();
        repeat (3) cyc();
        chk("b_queue_empty", 128'(q.size()), 128'(0));
        chk("b_frame_done_count", 128'(fd_b), 128'(200));
        chk("b_no_seq_err", 128'(b_err), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aq_axis_djpeg_pack.md
# aq_axis_djpeg_pack

Parametrised pixel-packing output stage for the JPEG decoder. It accepts one decoded pixel per handshake together with its coordinates and the frame size. It packs `PPB` pixels per AXI4-Stream beat, buffers the beats in a FIFO, and drives a master AXI4-Stream with byte-lane keep, a start-of-frame user bit, and selectable line/frame TLAST. It sits between the decoder core's pixel output and the video DMA, and replaces the fixed one-pixel, frame-TLAST-only output mapping.

## Interface
Parameters:
- `PPB`, default 2: pixels per beat; one of 1, 2, 4.
- `FIFO_DEPTH`, default 16: beat FIFO entries; a power of two, at least 2.

Ports:
- `TCLK`  in  1  clock.
- `RST`  in  1  reset; synchronous, active-high.
- `LAST_MODE`  in  1  0 = TLAST on end of frame, 1 = TLAST on end of line. Change only while the FIFO is empty.
- `CLR_ERR`  in  1  clears `SEQ_ERR`.
- `S_PIX_VALID`  in  1  pixel valid.
- `S_PIX_READY`  out  1  pixel ready.
- `S_PIX_R`, `S_PIX_G`, `S_PIX_B`  in  8 each  colour components.
- `S_PIX_X`, `S_PIX_Y`  in  16 each  pixel coordinates.
- `S_WIDTH`, `S_HEIGHT`  in  16 each  frame size.
- `M_AXIS_TDATA`  out  32*PPB  lane k = bits [32k+31:32k] = {8'd0,R,G,B}.
- `M_AXIS_TKEEP`  out  4*PPB  byte enables; `M_AXIS_TSTRB` equals `M_AXIS_TKEEP`.
- `M_AXIS_TUSER`  out  1  start of frame.
- `M_AXIS_TLAST`  out  1  end of line or frame, per `LAST_MODE`.
- `M_AXIS_TVALID`  out  1 / `M_AXIS_TREADY`  in  1  stream handshake.
- `FIFO_LEVEL`  out  log2(FIFO_DEPTH)+1  occupied entries.
- `FRAME_DONE`  out  1  one-cycle pulse on the output handshake of an end-of-frame beat.
- `SEQ_ERR`  out  1  sticky sequence-error flag.

## Operation
- **Accept rule:** a pixel is accepted when `S_PIX_VALID && S_PIX_READY`. `S_PIX_READY = !RST_d && !full`, where `full` is the registered state (FIFO_LEVEL == FIFO_DEPTH). A same-cycle pop does not raise ready.
- **Accumulator:** holds a lane counter (0..PPB-1), the partial data, the keep bits and a SOF flag. An accepted pixel is written to the lane given by the lane counter; that lane's 4 keep bits are set.
- **Flush:** the beat is flushed into the FIFO in the same cycle as the accepting pixel when lane == PPB-1 or `S_PIX_X == S_WIDTH-1` (eol). After a flush the lane counter returns to 0 and data/keep clear. Unused lanes carry zero data and zero keep. Beats never span lines.
- **FIFO entry:** {data, keep, sof, eol, eof}.
  - sof is set if the beat contains pixel (0,0).
  - eof = eol && `S_PIX_Y == S_HEIGHT-1`.
- **Output:** first-word-fall-through. `M_AXIS_TVALID = !empty`. TDATA/TKEEP/TUSER come from the head entry. `M_AXIS_TLAST = LAST_MODE ? eol : eof`. Pop on `TVALID && TREADY`. TVALID never drops without a handshake.
- **Sequence check:** expected X is 0 after reset or eol, otherwise previous X+1.
  - An accepted pixel with X ≠ expected sets `SEQ_ERR`. The pixel is still packed, and expected X resynchronises to X+1.
  - `S_WIDTH == 0` or `S_HEIGHT == 0`: the pixel is accepted and dropped, and `SEQ_ERR` is set.
  - `CLR_ERR` clears the flag; a simultaneous set wins.
- **Arithmetic:** all coordinate comparisons are 16-bit unsigned. `FIFO_LEVEL` increments on push, decrements on pop, and is unchanged when both happen.

## Timing
- **Reset values:** while `RST` is high and on the first cycle after, all outputs are 0: TVALID, TDATA, TKEEP, TUSER, TLAST, `S_PIX_READY`, `FIFO_LEVEL`, `FRAME_DONE`, `SEQ_ERR`.
- **Reset mid-frame:** discards the FIFO contents, the partial accumulator and expected X.
- **Latency:** a pixel that completes a beat is accepted at edge N; TVALID is asserted with that beat after edge N (visible in cycle N+1).
- **Throughput:** 1 pixel/cycle in; 1 beat/cycle out.
- **Full FIFO:** `S_PIX_READY` deasserts the cycle after the push that fills it, and reasserts the cycle after a pop.
- **Empty FIFO with push:** TVALID is visible the next cycle; there is no bypass.
- **FRAME_DONE:** registered; asserted the cycle after the handshake of an eof beat.

## Test plan
- **Packing:** PPB=2, W=5, H=2, TREADY=1, LAST_MODE=0 → 6 beats.
  - Beat 0 has TUSER=1 and TKEEP=0xFF.
  - Beats 2 and 5 have TKEEP=0x0F with upper lane data 0.
  - Only beat 5 has TLAST; FRAME_DONE pulses once.
- **Line TLAST:** same stream with LAST_MODE=1 → TLAST on beats 2 and 5.
- **Backpressure:** FIFO_DEPTH=4, TREADY=0, 10 pixels offered → 8 accepted, FIFO_LEVEL=4, `S_PIX_READY`=0. Releasing TREADY yields 4 beats in order, with no loss or duplication.
- **Sequence error:** X sequence 0,1,3 → SEQ_ERR=1 after pixel 3, which is still output in lane 0 of beat 1. CLR_ERR → 0. W=0 → pixel dropped and SEQ_ERR=1.
- **Reset mid-frame:** RST pulsed after 3 pixels of a frame → TVALID=0 and FIFO_LEVEL=0. The next frame's beat 0 has TUSER=1 and no stale lanes.
- **Random:** PPB=4, random VALID/READY over 200 frames of random size ≤ 17×9 → scoreboard match of every beat.
